// File: rtl/mult_bist_pkg.sv
// Shared types and constants for the multiplier BIST controller.
// Contents: FSM state enum, test vector struct, fixed vector table lookup,
// NO_FAIL marker for first_fail, LFSR seed and a saturating increment helper.
package mult_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitBusy,
    StWaitDone,
    StCheck,
    StDone
  } state_e;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
  } vec_t;

  localparam logic [4:0]  NO_FAIL   = 5'h1F;
  // Largest reportable vector index; indices beyond it are clamped here.
  localparam logic [4:0]  FF_MAX    = 5'h1E;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fixed vector table; entries past NUM_VEC are simply never visited.
  function automatic vec_t get_vec(input logic [3:0] idx);
    vec_t v;
    unique case (idx)
      4'd0:    v = '{8'd3,   8'd4,   16'd12};
      4'd1:    v = '{8'd5,   8'd12,  16'd60};
      4'd2:    v = '{8'd8,   8'd7,   16'd56};
      4'd3:    v = '{8'd1,   8'd1,   16'd1};
      4'd4:    v = '{8'd2,   8'd2,   16'd4};
      4'd5:    v = '{8'd255, 8'd255, 16'd65025};
      4'd6:    v = '{8'd0,   8'd200, 16'd0};
      4'd7:    v = '{8'd16,  8'd16,  16'd256};
      4'd8:    v = '{8'd10,  8'd25,  16'd250};
      4'd9:    v = '{8'd100, 8'd3,   16'd300};
      4'd10:   v = '{8'd128, 8'd2,   16'd256};
      4'd11:   v = '{8'd15,  8'd17,  16'd255};
      4'd12:   v = '{8'd200, 8'd100, 16'd20000};
      4'd13:   v = '{8'd7,   8'd9,   16'd63};
      4'd14:   v = '{8'd255, 8'd1,   16'd255};
      default: v = '{8'd12,  8'd12,  16'd144};
    endcase
    return v;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/mult_bist_if.sv
// Handshake/operand bundle between the BIST controller and the multiplier
// under test.
//   m_rst   : reset to the multiplier (controller -> multiplier)
//   m_start : start request
//   m_a/m_b : 8-bit operands
//   m_ready : multiplier idle and able to accept start
//   m_busy  : multiplier computing
//   m_y     : 16-bit product, valid when m_busy falls
interface mult_bist_if;
  logic        m_rst;
  logic        m_start;
  logic [7:0]  m_a;
  logic [7:0]  m_b;
  logic        m_ready;
  logic        m_busy;
  logic [15:0] m_y;

  modport master (
    output m_rst, m_start, m_a, m_b,
    input  m_ready, m_busy, m_y
  );

  modport slave (
    input  m_rst, m_start, m_a, m_b,
    output m_ready, m_busy, m_y
  );
endinterface

// File: rtl/mult_bist_lfsr.sv
// 16-bit maximal-length Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (loads the seed)
//   load : reload the seed 16'hACE1
//   step : advance one state (load has priority)
//   q    : current LFSR state
module mult_bist_lfsr
  import mult_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = LFSR_SEED;
    end else if (step) begin
      q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= LFSR_SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mult_bist.sv
// Built-in self test controller for a handshaked 8x8 multiplier.
// On a run pulse it walks a fixed vector table (and, with MULT_BIST_LFSR_EN
// defined, LFSR_VEC pseudo-random vectors after it), drives each vector through
// the start/busy handshake, compares the product and counts passes/failures.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   run        : one-cycle start request (honoured only in idle/done)
//   mif        : multiplier handshake bundle (master side)
//   done       : pass complete, held until next run or rst
//   pass_cnt   : saturating count of passing vectors
//   fail_cnt   : saturating count of failing vectors
//   first_fail : index of first failing vector, 5'h1F when none
// Optional feature macro: MULT_BIST_LFSR_EN.
module mult_bist
  import mult_bist_pkg::*;
#(
  parameter int unsigned NUM_VEC  = 5,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned LFSR_VEC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  mult_bist_if.master        mif,
  output logic               done,
  output logic [7:0]         pass_cnt,
  output logic [7:0]         fail_cnt,
  output logic [4:0]         first_fail
);

`ifdef MULT_BIST_LFSR_EN
  localparam bit LfsrEn = 1'b1;
`else
  localparam bit LfsrEn = 1'b0;
`endif
  // Total vectors per pass; assumed to stay below 256.
  localparam int unsigned Total = NUM_VEC + (LfsrEn ? LFSR_VEC : 0);
  localparam int unsigned PhW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e         state_q, state_d;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     a_q, a_d, b_q, b_d;
  logic [15:0]    exp_q, exp_d, y_q, y_d;
  logic           tmo_q, tmo_d;
  logic           start_q, start_d;
  logic [7:0]     pass_q, pass_d, fail_q, fail_d;
  logic [4:0]     ff_q, ff_d;
  logic           done_q, done_d;
  logic [PhW-1:0] phase_q, phase_d;

  logic           tmo;
  logic [7:0]     ld_idx;
  vec_t           ld_vec;
  logic [4:0]     ff_idx;

  assign tmo    = (phase_q == PhW'(TIMEOUT - 1));
  // Index of the vector about to be loaded: 0 on a new pass, else the next one.
  assign ld_idx = (state_q == StCheck) ? idx_q + 8'd1 : 8'd0;
  assign ff_idx = (idx_q >= 8'd30) ? FF_MAX : idx_q[4:0];

`ifdef MULT_BIST_LFSR_EN
  logic        lfsr_load, lfsr_step;
  logic [15:0] lfsr_q;

  mult_bist_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  always_comb begin
    if (ld_idx >= 8'(NUM_VEC)) begin
      ld_vec.a = lfsr_q[15:8];
      ld_vec.b = lfsr_q[7:0];
      ld_vec.y = 16'(lfsr_q[15:8]) * 16'(lfsr_q[7:0]);
    end else begin
      ld_vec = get_vec(ld_idx[3:0]);
    end
  end
`else
  always_comb begin
    ld_vec = '0;
    if (ld_idx < 8'(NUM_VEC)) ld_vec = get_vec(ld_idx[3:0]);
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    exp_d   = exp_q;
    y_d     = y_q;
    tmo_d   = tmo_q;
    start_d = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ff_d    = ff_q;
    done_d  = done_q;
`ifdef MULT_BIST_LFSR_EN
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (run) begin
          state_d = StLoad;
          idx_d   = 8'd0;
          pass_d  = 8'd0;
          fail_d  = 8'd0;
          ff_d    = NO_FAIL;
          done_d  = 1'b0;
          a_d     = ld_vec.a;
          b_d     = ld_vec.b;
          exp_d   = ld_vec.y;
`ifdef MULT_BIST_LFSR_EN
          lfsr_load = 1'b1;
`endif
        end
      end
      StLoad: begin
        tmo_d   = 1'b0;
        state_d = StStart;
`ifdef MULT_BIST_LFSR_EN
        // Operands were captured on entry, so advance now for the next vector.
        lfsr_step = (idx_q >= 8'(NUM_VEC));
`endif
      end
      StStart: begin
        if (mif.m_ready) begin
          start_d = 1'b1;
          state_d = StWaitBusy;
        end else if (tmo) begin
          tmo_d   = 1'b1;
          state_d = StCheck;
        end
      end
      StWaitBusy: begin
        if (mif.m_busy) begin
          state_d = StWaitDone;
        end else if (tmo) begin
          tmo_d   = 1'b1;
          state_d = StCheck;
        end else begin
          start_d = 1'b1;
        end
      end
      StWaitDone: begin
        if (!mif.m_busy) begin
          y_d     = mif.m_y;
          state_d = StCheck;
        end else if (tmo) begin
          tmo_d   = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (tmo_q || (y_q != exp_q)) begin
          fail_d = sat_inc(fail_q);
          if (ff_q == NO_FAIL) ff_d = ff_idx;
        end else begin
          pass_d = sat_inc(pass_q);
        end
        if (ld_idx < 8'(Total)) begin
          state_d = StLoad;
          idx_d   = ld_idx;
          a_d     = ld_vec.a;
          b_d     = ld_vec.b;
          exp_d   = ld_vec.y;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Phase counter restarts on every state change and parks at the limit.
  always_comb begin
    if (state_d != state_q) phase_d = '0;
    else if (tmo)           phase_d = phase_q;
    else                    phase_d = phase_q + PhW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 8'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      exp_q   <= 16'd0;
      y_q     <= 16'd0;
      tmo_q   <= 1'b0;
      start_q <= 1'b0;
      pass_q  <= 8'd0;
      fail_q  <= 8'd0;
      ff_q    <= NO_FAIL;
      done_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exp_q   <= exp_d;
      y_q     <= y_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ff_q    <= ff_d;
      done_q  <= done_d;
      phase_q <= phase_d;
    end
  end

  assign mif.m_rst   = (state_q == StIdle) || (state_q == StLoad) || (state_q == StDone);
  assign mif.m_start = start_q;
  assign mif.m_a     = a_q;
  assign mif.m_b     = b_q;
  assign done        = done_q;
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign first_fail  = ff_q;

endmodule
